float_discriminant_scheduler: RTL and testbench

- Parametrised successor to the fixed 20-way round-robin discriminant distributor.
- Owns N_UNITS instances of float_discriminant and dispatches each accepted (a, b, c) triple to the next free unit, skipping occupied units.
- Results are reassembled in issue order through a reorder buffer (ROB).
- Valid/ready handshakes on both input and output give full backpressure, so sub-unit latency variation never reorders or drops results.

---
 rtl/float_discriminant_scheduler_pkg.sv | 22 ++
 rtl/float_discriminant.sv | 74 +++++++
 rtl/float_discriminant_scheduler_rob.sv | 51 +++++
 rtl/float_discriminant_scheduler.sv | 102 ++++++++++
 tb/tb_float_discriminant_scheduler.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/float_discriminant_scheduler_pkg.sv
// float_disc_sched_pkg: shared types and helpers for the discriminant scheduler
package float_disc_sched_pkg;
  localparam int FLEN = 32;
  typedef struct packed {
    logic [FLEN-1:0] res;
    logic neg;
    logic err;
  } rob_entry_t;
  function automatic int tag_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // {found, index} of the first free unit at or after rr_ptr, wrapping modulo n
  function automatic logic [5:0] next_free(input logic [31:0] occupied, input logic [4:0] rr_ptr, input int n);
    int j;
    next_free = '0;
    for (int i = 31; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= n) j -= n;
      if (i < n && !occupied[j]) next_free = {1'b1, 5'(j)};
    end
  endfunction
endpackage

// File: rtl/float_discriminant.sv
// float_discriminant: two-stage binary32 b*b-4*a*c, truncating, denormals flushed, NaN/Inf/overflow set err
module float_discriminant
  import float_disc_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            res_vld,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err
);
  function automatic logic [23:0] mant(input logic [30:0] x);
    return x[30:23] == 8'd0 ? 24'd0 : {1'b1, x[22:0]};
  endfunction
  logic v1, s1, sp1, neg, e, unused_b_sign;
  logic [47:0] pb, pc, pbb, pac;
  logic [9:0] xb, xc, xm;
  logic [72:0] va, vc, s;
  logic [6:0] p;
  logic [10:0] t;
  logic [22:0] frac;
  logic [31:0] r;
  assign unused_b_sign = b[31];
  always_comb begin
    pbb = mant(b[30:0]) * mant(b[30:0]);
    pac = mant(a[30:0]) * mant(c[30:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else v1 <= arg_vld;
    if (arg_vld) begin
      pb  <= pbb;
      pc  <= pac;
      xb  <= pbb == '0 ? '0 : {1'b0, b[30:23], 1'b0};
      xc  <= pac == '0 ? '0 : 10'(a[30:23]) + 10'(c[30:23]) + 10'd2;
      s1  <= a[31] ^ c[31];
      sp1 <= &a[30:23] | &b[30:23] | &c[30:23];
    end
  end
  // sum is scaled by 2^(xm-324); exponent bias folds into the 197 offset
  always_comb begin
    xm = xb > xc ? xb : xc;
    va = {1'b0, pb, 24'd0} >> (xm - xb);
    vc = {1'b0, pc, 24'd0} >> (xm - xc);
    neg = !s1 && vc > va;
    s = s1 ? va + vc : neg ? vc - va : va - vc;
    p = '0;
    for (int i = 0; i < 73; i++) if (s[i]) p = 7'(i);
    t = 11'(p) + 11'(xm);
    frac = 23'((s << (7'd72 - p)) >> 49);
    e = sp1 || (s != '0 && t >= 11'd452);
    r = sp1 ? 32'h7fc00000 : (s == '0 || t <= 11'd197) ? 32'd0 :
        t >= 11'd452 ? {neg, 8'hff, 23'd0} : {neg, 8'(t - 11'd197), frac};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res <= '0;
      res_negative <= 1'b0;
      err <= 1'b0;
    end else begin
      res_vld <= v1;
      if (v1) begin
        res <= r;
        res_negative <= r[31];
        err <= e;
      end
    end
  end
endmodule

// File: rtl/float_discriminant_scheduler_rob.sv
// float_disc_rob: reorder buffer with one write port per unit and an in-order pop
module float_disc_rob
  import float_disc_sched_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int DEPTH = 8,
  localparam int TW = tag_bits(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop_rdy,
  input  logic [N_UNITS-1:0] wr_vld,
  input  logic [TW-1:0]      wr_tag [N_UNITS],
  input  rob_entry_t         wr_data [N_UNITS],
  output logic [TW-1:0]      tail,
  output logic               head_vld,
  output rob_entry_t         head_data,
  output logic [CW-1:0]      count
);
  rob_entry_t ent [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [TW-1:0] head;
  logic pop;
  assign head_vld = vld[head];
  assign head_data = ent[head];
  assign pop = head_vld && pop_rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        ent[head] <= '0;
        head <= head == TW'(DEPTH - 1) ? '0 : head + 1'b1;
      end
      if (push) tail <= tail == TW'(DEPTH - 1) ? '0 : tail + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      for (int i = 0; i < N_UNITS; i++)
        if (wr_vld[i]) begin
          ent[wr_tag[i]] <= wr_data[i];
          vld[wr_tag[i]] <= 1'b1;
        end
    end
  end
endmodule

// File: rtl/float_discriminant_scheduler.sv
// float_discriminant_scheduler: dispatches triples to free units, returns results in order
// Optional statistics counters: define FLOAT_DISC_SCHED_STATS_EN
module float_discriminant_scheduler
  import float_disc_sched_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int ROB_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  output logic            arg_rdy,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err,
  output logic            busy
`ifdef FLOAT_DISC_SCHED_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_errors,
  output logic [31:0]     stat_stall
`endif
);
  localparam int TW = tag_bits(ROB_DEPTH);
  localparam int UW = tag_bits(N_UNITS);
  localparam int CW = $clog2(ROB_DEPTH + 1);
  logic [N_UNITS-1:0] occupied, go, done, u_neg, u_err;
  logic [UW-1:0] rr_ptr, sel;
  logic [5:0] pick;
  logic [FLEN-1:0] op_a, op_b, op_c;
  logic [FLEN-1:0] u_res [N_UNITS];
  logic [TW-1:0] tag [N_UNITS];
  logic [TW-1:0] tail;
  logic [CW-1:0] count;
  rob_entry_t wr_data [N_UNITS];
  rob_entry_t head;
  logic head_vld, accept;
  always_comb begin
    pick = next_free(32'(occupied), 5'(rr_ptr), N_UNITS);
    sel = UW'(pick[4:0]);
    arg_rdy = !rst && count < CW'(ROB_DEPTH) && pick[5];
    accept = arg_vld && arg_rdy;
    res_vld = !rst && head_vld;
    res = rst ? '0 : head.res;
    res_negative = !rst && head.neg;
    err = !rst && head.err;
    busy = !rst && count != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= '0;
      rr_ptr <= '0;
      go <= '0;
      op_a <= '0;
      op_b <= '0;
      op_c <= '0;
      for (int i = 0; i < N_UNITS; i++) tag[i] <= '0;
    end else begin
      go <= '0;
      occupied <= occupied & ~done;
      if (accept) begin
        occupied[sel] <= 1'b1;
        go[sel] <= 1'b1;
        tag[sel] <= tail;
        op_a <= a;
        op_b <= b;
        op_c <= c;
        rr_ptr <= sel == UW'(N_UNITS - 1) ? '0 : sel + 1'b1;
      end
    end
  end
  for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
    float_discriminant u_disc (
      .clk(clk), .rst(rst), .arg_vld(go[i]), .a(op_a), .b(op_b), .c(op_c),
      .res_vld(done[i]), .res(u_res[i]), .res_negative(u_neg[i]), .err(u_err[i])
    );
    assign wr_data[i] = '{res: u_res[i], neg: u_neg[i], err: u_err[i]};
  end
  float_disc_rob #(.N_UNITS(N_UNITS), .DEPTH(ROB_DEPTH)) u_rob (
    .clk(clk), .rst(rst), .push(accept), .pop_rdy(res_rdy), .wr_vld(done),
    .wr_tag(tag), .wr_data(wr_data), .tail(tail), .head_vld(head_vld),
    .head_data(head), .count(count)
  );
`ifdef FLOAT_DISC_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_errors <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && stat_issued != '1) stat_issued <= stat_issued + 1'b1;
      if (res_vld && res_rdy && head.err && stat_errors != '1) stat_errors <= stat_errors + 1'b1;
      if (arg_vld && !arg_rdy && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_float_discriminant_scheduler.sv
// tb_float_discriminant_scheduler: directed vectors for the in-order discriminant scheduler
module tb_float_discriminant_scheduler;
  localparam logic [31:0] ONE = 32'h3f800000, TWO = 32'h40000000, FOUR = 32'h40800000;
  localparam logic [31:0] EIGHT = 32'h41000000, MTHREE = 32'hc0400000, QNAN = 32'h7fc00000;
  logic clk = 1'b0, rst = 1'b1, arg_vld = 1'b0, res_rdy = 1'b1;
  logic [31:0] a = '0, b = '0, c = '0, res;
  logic arg_rdy, res_vld, res_negative, err, busy;
  int vectors = 0, miscompares = 0, sent, got;
  bit acc;
`ifdef FLOAT_DISC_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_errors, stat_stall;
`endif

  float_discriminant_scheduler dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .res_negative(res_negative),
    .err(err), .busy(busy)
`ifdef FLOAT_DISC_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_errors(stat_errors), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] itof(input int n);
    int p;
    p = 0;
    if (n == 0) return 32'd0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    return {1'b0, 8'(127 + p), 23'(n << (23 - p))};
  endfunction

  task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] cc);
    @(posedge clk); #1;
    arg_vld = 1'b1; a = aa; b = bb; c = cc;
    @(negedge clk);
    chk("issue_rdy", arg_rdy, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_arg_rdy", arg_rdy, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arg_rdy", arg_rdy, 1);

    issue(ONE, FOUR, TWO);
    @(posedge clk); #1;
    arg_vld = 1'b0;
    @(negedge clk);
    chk("single_busy", busy, 1);
    chk("single_early1", res_vld, 0);
    @(negedge clk);
    chk("single_early2", res_vld, 0);
    @(negedge clk);
    chk("single_early3", res_vld, 0);
    @(negedge clk);
    chk("single_vld", res_vld, 1);
    chk("single_res", res, EIGHT);
    chk("single_neg", res_negative, 0);
    chk("single_err", err, 0);
    @(negedge clk);
    chk("single_done_vld", res_vld, 0);
    chk("single_done_busy", busy, 0);

    issue(ONE, QNAN, ONE);
    issue(ONE, ONE, ONE);
    @(posedge clk); #1;
    arg_vld = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("nan_vld", res_vld, 1);
    chk("nan_err", err, 1);
    @(negedge clk);
    chk("neg_vld", res_vld, 1);
    chk("neg_res", res, MTHREE);
    chk("neg_neg", res_negative, 1);
    chk("neg_err", err, 0);
    @(negedge clk);
    chk("neg_done", res_vld, 0);

    acc = 1'b0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 24; cyc++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      arg_vld = sent < 24; a = ONE; b = itof(sent + 1); c = '0;
      @(negedge clk);
      if (arg_vld) chk("stream_rdy", arg_rdy, 1);
      if (got > 0) chk("stream_gap", res_vld, 1);
      if (res_vld) begin
        if (got == 0) chk("stream_lat", cyc, 4);
        chk("stream_res", res, itof((got + 1) * (got + 1)));
        got++;
      end
      acc = arg_vld && arg_rdy;
    end
    chk("stream_count", got, 24);

    acc = 1'b0; sent = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      res_rdy = 1'b0; arg_vld = 1'b1; a = ONE; b = itof(sent + 1); c = '0;
      @(negedge clk);
      acc = arg_rdy;
    end
    @(posedge clk); #1;
    if (acc) sent++;
    arg_vld = 1'b0;
    chk("bp_accepts", sent, 8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rdy", arg_rdy, 0);
      chk("bp_vld", res_vld, 1);
      chk("bp_hold", res, itof(1));
      chk("bp_busy", busy, 1);
    end
    @(posedge clk); #1;
    res_rdy = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
      @(negedge clk);
      if (res_vld) begin
        chk("drain_res", res, itof((got + 1) * (got + 1)));
        got++;
      end
    end
    chk("drain_count", got, 8);
    @(negedge clk);
    chk("drain_busy", busy, 0);

    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      res_rdy = 1'b0; arg_vld = 1'b1; a = ONE; b = itof(k + 1); c = '0;
      @(negedge clk);
      chk("fill_rdy", arg_rdy, 1);
    end
    @(posedge clk); #1;
    arg_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_arg_rdy", arg_rdy, 0);
    chk("mid_rst_res_vld", res_vld, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_neg", res_negative, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0; res_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_stale", res_vld, 0);
      chk("post_rst_busy", busy, 0);
    end
    issue(ONE, FOUR, TWO);
    @(posedge clk); #1;
    arg_vld = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("fresh_vld", res_vld, 1);
    chk("fresh_res", res, EIGHT);
    @(negedge clk);
    chk("fresh_done", res_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
